// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows / bypass stage for NB = 4, 6 or 8 columns, with mode chosen per beat.
// Latency: one cycle from accept to m_valid. Backpressure: a 2-entry FIFO; s_ready is registered and low only when both entries are full.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [32*NB-1:0]   s_data,
  input  logic [1:0]         s_mode,
  input  logic [TAG_W-1:0]   s_tag,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [32*NB-1:0]   m_data,
  output logic [TAG_W-1:0]   m_tag
);

  localparam int DW = 32 * NB;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    dat;
  } beat_t;

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  // Row rotation amount; the 256-bit state skips one extra column on rows 2 and 3.
  function automatic int row_off(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  logic [DW-1:0] fwd_dat;
  logic [DW-1:0] inv_dat;
  logic [DW-1:0] xf_dat;

  always_comb begin
    fwd_dat = '0;
    inv_dat = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        fwd_dat[DW-1-8*(r+4*c) -: 8] = s_data[DW-1-8*(r+4*((c+row_off(r))%NB)) -: 8];
        inv_dat[DW-1-8*(r+4*c) -: 8] = s_data[DW-1-8*(r+4*((c-row_off(r)+NB)%NB)) -: 8];
      end
    end
  end

  assign xf_dat = s_mode[1] ? s_data : (s_mode[0] ? inv_dat : fwd_dat);

  beat_t      mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_nxt;
  logic       push;
  logic       pop;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 2'd1;
    end else if (pop && !push) begin
      count_nxt = count - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      s_ready <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{tag: s_tag, dat: xf_dat};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count   <= count_nxt;
      // Ready is looked ahead from the next occupancy so it can come straight from a flop.
      s_ready <= (count_nxt != 2'd2);
    end
  end

  assign m_valid = (count != 2'd0);
  assign m_data  = mem[rd_ptr].dat;
  assign m_tag   = mem[rd_ptr].tag;

endmodule
